// File: rtl/fifo_async_pkg.sv
// Shared constants for the async FIFO family: skid buffer depth and its occupancy width.
// Also holds the occupancy update helper used by the read-side skid buffer.
package fifo_async_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    function automatic logic [SKID_CNT_W-1:0] skid_next_cnt(
        input logic [SKID_CNT_W-1:0] cnt,
        input logic                  inc,
        input logic                  dec
    );
        return cnt + SKID_CNT_W'(inc) - SKID_CNT_W'(dec);
    endfunction

endpackage

// File: rtl/fifo_pop_stream_if.sv
// FIFO read-side and valid/accept stream signals seen by fifo_pop_stream.
// master is the consumer block's view; slave is the surrounding FIFO/sink view.
interface fifo_pop_stream_if #(
    parameter int W = 32
);
    logic         empty_r;
    logic [W-1:0] pop_data;
    logic         pop;
    logic         out_vld;
    logic [W-1:0] out_data;
    logic         out_accept;

    modport master (
        input  empty_r, pop_data, out_accept,
        output pop, out_vld, out_data
    );

    modport slave (
        output empty_r, pop_data, out_accept,
        input  pop, out_vld, out_data
    );
endinterface

// File: rtl/fifo_pop_skid.sv
// Two-entry circular skid buffer that absorbs the FIFO's one-cycle read latency.
// The head word is presented directly from storage, so rdata has no path from ren.
module fifo_pop_skid
    import fifo_async_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [W-1:0]          wdata,
    input  logic                  ren,
    output logic [W-1:0]          rdata,
    output logic [SKID_CNT_W-1:0] cnt
);

    logic [W-1:0]          buf_q [SKID_DEPTH];
    logic                  rd_ptr_q;
    logic                  rd_ptr_d;
    logic                  wr_ptr_q;
    logic                  wr_ptr_d;
    logic [SKID_CNT_W-1:0] cnt_q;
    logic [SKID_CNT_W-1:0] cnt_d;

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = skid_next_cnt(cnt_q, wen, ren);
        if (ren) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wen) begin
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Storage, pointers and occupancy registers; reset clears the stored words too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (wen) begin
                buf_q[wr_ptr_q] <= wdata;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rdata = buf_q[rd_ptr_q];
    assign cnt   = cnt_q;

endmodule

// File: rtl/fifo_pop_stream.sv
// Read-side consumer for fifo_async: issues pops and re-presents words as a valid/accept
// stream at one word per cycle, using a 2-entry skid buffer to cover the read latency.
module fifo_pop_stream
    import fifo_async_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst,
    fifo_pop_stream_if.master bus
);

    logic                  inflight_q;
    logic                  inflight_d;
    logic                  vld_s;
    logic                  deq_s;
    logic                  pop_s;
    logic [2:0]            need_s;
    logic [SKID_CNT_W-1:0] cnt_s;
    logic [W-1:0]          rdata_s;

    // Pop whenever the words held plus the one in flight, after this cycle's dequeue,
    // leave room; deq implies cnt >= 1 so the 3-bit sum never underflows.
    always_comb begin
        vld_s      = (cnt_s != '0);
        deq_s      = vld_s & bus.out_accept;
        need_s     = 3'(cnt_s) + 3'(inflight_q) - 3'(deq_s);
        pop_s      = ~rst & ~bus.empty_r & (need_s < 3'd2);
        inflight_d = pop_s;
    end

    // In-flight flag: the FIFO returns pop_data one cycle after pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_pop_skid #(
        .W (W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .wen   (inflight_q),
        .wdata (bus.pop_data),
        .ren   (deq_s),
        .rdata (rdata_s),
        .cnt   (cnt_s)
    );

    assign bus.pop      = pop_s;
    assign bus.out_vld  = vld_s;
    assign bus.out_data = rdata_s;

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Self-checking bench for fifo_pop_stream: a queue-based FIFO model feeds the DUT and a
// scoreboard tracks pulled/delivered words to predict pop, out_vld and out_data each cycle.
module tb_fifo_pop_stream;

    logic clk;
    logic rst;

    fifo_pop_stream_if #(.W(32)) bus ();

    fifo_pop_stream #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        push;
        logic [31:0] word;
        logic        acc;
        logic        exp_pop;
        logic        exp_vld;
        logic [31:0] exp_data;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] fq[$];
    logic [31:0] sb[$];
    logic [31:0] deq_log[$];
    int          popped    = 0;
    int          delivered = 0;
    logic        last_pop  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        s_pop;
    logic        s_vld;
    logic [31:0] s_data;
    int          n_pops = 0;
    int          cyc = 0;
    int          first_deq = -1;
    int          last_deq = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fq.push_back(w);
        sb.push_back(w);
    endtask

    // One clock cycle: drive, sample at the falling edge, compare with the model, advance.
    task automatic cycle(input logic acc);
        int   outstanding;
        int   inbuf;
        logic exp_vld;
        logic exp_pop;
        logic deq;
        bus.out_accept = acc;
        bus.empty_r    = (fq.size() == 0);
        #4;
        s_pop  = bus.pop;
        s_vld  = bus.out_vld;
        s_data = bus.out_data;
        outstanding = popped - delivered;
        inbuf       = outstanding - (last_pop ? 1 : 0);
        exp_vld     = (inbuf > 0);
        deq         = exp_vld & acc;
        exp_pop     = !bus.empty_r && ((outstanding - (deq ? 1 : 0)) < 2);
        chk("out_vld", 32'(s_vld), 32'(exp_vld));
        chk("pop", 32'(s_pop), 32'(exp_pop));
        if (exp_vld && sb.size() > 0) chk("out_data", s_data, sb[0]);
        chk("held_plus_inflight_le_2", 32'(outstanding <= 2), 32'd1);
        chk("no_pop_when_empty", 32'(s_pop & bus.empty_r), 32'd0);
        if (prev_stall) begin
            chk("stall_vld_stable", 32'(s_vld), 32'd1);
            chk("stall_data_stable", s_data, prev_data);
        end
        prev_stall = s_vld & ~acc;
        prev_data  = s_data;
        @(posedge clk);
        #1;
        if (s_vld && acc) begin
            if (sb.size() > 0) void'(sb.pop_front());
            deq_log.push_back(s_data);
            delivered++;
            if (first_deq < 0) first_deq = cyc;
            last_deq = cyc;
        end
        if (s_pop) begin
            if (fq.size() > 0) bus.pop_data = fq.pop_front();
            popped++;
            n_pops++;
        end
        last_pop = s_pop;
        cyc++;
    endtask

    vec_t vecs[11];

    initial begin
        int d0;
        int pushed;
        logic        a_vld;
        logic [31:0] a_data;

        vecs[0]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0022, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0011};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0011};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0022};
        vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0011};

        rst            = 1'b1;
        bus.empty_r    = 1'b1;
        bus.pop_data   = 32'd0;
        bus.out_accept = 1'b0;
        #2;
        chk("reset_pop", 32'(bus.pop), 32'd0);
        chk("reset_vld", 32'(bus.out_vld), 32'd0);
        chk("reset_data", bus.out_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word and empty edge: table of per-cycle inputs and expected outputs.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].push) push_word(vecs[i].word);
            cycle(vecs[i].acc);
            chk($sformatf("vec%0d_pop", i), 32'(s_pop), 32'(vecs[i].exp_pop));
            chk($sformatf("vec%0d_vld", i), 32'(s_vld), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_data", i), s_data, vecs[i].exp_data);
        end

        // Streaming: 32 words with out_accept held high.
        d0 = delivered;
        first_deq = -1;
        for (int w = 0; w < 32; w++) push_word(32'(w));
        for (int c = 0; c < 80 && (delivered - d0) < 32; c++) cycle(1'b1);
        chk("stream_count", 32'(delivered - d0), 32'd32);
        chk("stream_no_bubbles", 32'(last_deq - first_deq + 1), 32'd32);

        // Stall: 8 words, out_accept low for 10 cycles, then drain.
        d0 = delivered;
        n_pops = 0;
        for (int w = 0; w < 8; w++) push_word(32'(w));
        for (int c = 0; c < 10; c++) cycle(1'b0);
        chk("stall_pops", 32'(n_pops), 32'd2);
        chk("stall_head", s_data, 32'd0);
        bus.out_accept = 1'b0;
        #1;
        a_vld  = bus.out_vld;
        a_data = bus.out_data;
        bus.out_accept = 1'b1;
        #1;
        chk("accept_to_vld_comb", 32'(bus.out_vld), 32'(a_vld));
        chk("accept_to_data_comb", bus.out_data, a_data);
        bus.out_accept = 1'b0;
        for (int c = 0; c < 40 && sb.size() > 0; c++) cycle(1'b1);
        chk("stall_drain_count", 32'(delivered - d0), 32'd8);
        chk("stall_order_last", deq_log[deq_log.size() - 1], 32'd7);

        // Random out_accept against a random-rate FIFO of 1000 words.
        d0 = delivered;
        pushed = 0;
        for (int c = 0; c < 8000 && (delivered - d0) < 1000; c++) begin
            if (pushed < 1000 && $urandom_range(1, 0) == 1) begin
                push_word($urandom);
                pushed++;
            end
            cycle(1'($urandom_range(1, 0)));
        end
        chk("random_delivered", 32'(delivered - d0), 32'd1000);
        chk("random_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-stream with two words held.
        for (int w = 0; w < 8; w++) push_word(32'h100 + 32'(w));
        for (int c = 0; c < 4; c++) cycle(1'b0);
        chk("pre_reset_vld", 32'(s_vld), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_pop", 32'(bus.pop), 32'd0);
        chk("midrst_vld", 32'(bus.out_vld), 32'd0);
        chk("midrst_data", bus.out_data, 32'd0);
        fq.delete();
        sb.delete();
        deq_log.delete();
        popped = 0;
        delivered = 0;
        last_pop = 1'b0;
        prev_stall = 1'b0;
        bus.pop_data = 32'd0;
        bus.empty_r = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_word(32'hBEEF_0001);
        push_word(32'hBEEF_0002);
        for (int c = 0; c < 20 && delivered < 2; c++) cycle(1'b1);
        chk("post_reset_count", 32'(delivered), 32'd2);
        if (deq_log.size() > 0) chk("post_reset_first", deq_log[0], 32'hBEEF_0001);
        else chk("post_reset_first_present", 32'(deq_log.size()), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
